// File: rtl/vec_pkg.sv
// Shared types and default sizes for the vector operand path.
package vec_pkg;

    localparam int LANE_W     = 32;
    localparam int LANES      = 6;
    localparam int NUM_SCALAR = 3;
    localparam int V          = LANES * LANE_W;
    localparam int SEL_VEC    = 0;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_e;

endpackage

// File: rtl/vec_operand_select_skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready depends on registered state only.
import vec_pkg::*;

module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    skid_state_e  state;
    logic [W-1:0] head;
    logic [W-1:0] skid;
    logic         acc;
    logic         xfer;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign dout      = head;
    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        head  <= din;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        head <= din;
                    end else if (acc) begin
                        skid  <= din;
                        state <= FULL;
                    end else if (xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/vec_operand_select.sv
// Vector/scalar-broadcast operand select with lane masking, behind a skid buffer.
import vec_pkg::*;

module vec_operand_select #(
    parameter int LANE_W     = vec_pkg::LANE_W,
    parameter int LANES      = vec_pkg::LANES,
    parameter int NUM_SCALAR = vec_pkg::NUM_SCALAR,
    parameter int SEL_W      = $clog2(NUM_SCALAR + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*LANE_W-1:0]      vec_in,
    input  logic [NUM_SCALAR*LANE_W-1:0] scalar_in,
    input  logic [SEL_W-1:0]             sel,
    input  logic [LANES-1:0]             lane_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*LANE_W-1:0]      vec_out,
    output logic                         sel_err
);

    localparam int VW = LANES * LANE_W;

    logic              err;
    logic              is_vec;
    logic [LANE_W-1:0] bcast;
    logic [VW-1:0]     res;
    logic [VW:0]       head;

    assign is_vec = (sel == SEL_W'(SEL_VEC));
    assign err    = (int'(sel) > NUM_SCALAR);

    // bcast stays zero for an illegal select, which zeroes every lane
    always_comb begin
        bcast = '0;
        for (int k = 0; k < NUM_SCALAR; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                bcast = scalar_in[k*LANE_W +: LANE_W];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign res[i*LANE_W +: LANE_W] =
            !lane_mask[i] ? '0 :
            is_vec        ? vec_in[i*LANE_W +: LANE_W] :
                            bcast;
    end

    skid_buffer #(
        .W(VW + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      ({err, res}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (head)
    );

    assign vec_out = head[VW-1:0];
    assign sel_err = head[VW];

endmodule

// File: tb/tb_vec_operand_select.sv
// Self-checking bench for vec_operand_select with a queue-based scoreboard.
module tb_vec_operand_select;

    localparam int LW = 32;
    localparam int NL = 6;
    localparam int V  = LW * NL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [V-1:0]  vec_in, vec_out;
    logic [95:0]   scalar_in;
    logic [1:0]    sel;
    logic [5:0]    lane_mask;

    logic          in_valid2, in_ready2, out_valid2, out_ready2, sel_err2;
    logic [V-1:0]  vec_in2, vec_out2;
    logic [63:0]   scalar_in2;
    logic [1:0]    sel2;
    logic [5:0]    lane_mask2;

    int            tests = 0;
    int            fails = 0;
    logic [V:0]    sbq[$];

    always #5 clk = ~clk;

    vec_operand_select dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .scalar_in(scalar_in),
        .sel(sel), .lane_mask(lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .vec_out(vec_out), .sel_err(sel_err)
    );

    vec_operand_select #(.NUM_SCALAR(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .vec_in(vec_in2), .scalar_in(scalar_in2),
        .sel(sel2), .lane_mask(lane_mask2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .vec_out(vec_out2), .sel_err(sel_err2)
    );

    function automatic logic [V-1:0] rand_vec();
        logic [V-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = $urandom;
        return r;
    endfunction

    function automatic logic [V:0] model(input logic [V-1:0] v,
                                         input logic [95:0] s,
                                         input logic [1:0] sl,
                                         input logic [5:0] m,
                                         input int ns);
        logic [V:0] r;
        r = '0;
        if (int'(sl) > ns) begin
            r[V] = 1'b1;
        end else begin
            for (int i = 0; i < NL; i++)
                if (m[i])
                    r[i*LW +: LW] = (sl == 2'd0) ? v[i*LW +: LW]
                                                 : s[(int'(sl)-1)*LW +: LW];
        end
        return r;
    endfunction

    task automatic drive_rand();
        vec_in    = rand_vec();
        scalar_in = {$urandom, $urandom, $urandom};
        sel       = 2'($urandom_range(0, 3));
        lane_mask = 6'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; vec_in = '0; scalar_in = '0;
        sel = 0; lane_mask = '0;
        in_valid2 = 0; out_ready2 = 1; vec_in2 = '0; scalar_in2 = '0;
        sel2 = 0; lane_mask2 = '0;
        #3;
        tests++;
        if ({out_valid, in_ready, sel_err} !== 3'b010) begin
            fails++;
            $display("FAIL reset_ctrl: got ov/ir/err=%b exp 010",
                     {out_valid, in_ready, sel_err});
        end
        tests++;
        if (vec_out !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h exp 0", vec_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vector_pass();
        logic [V-1:0] exp;
        @(negedge clk);
        out_ready = 1; in_valid = 1; sel = 0; lane_mask = 6'b111111;
        scalar_in = {$urandom, $urandom, $urandom};
        for (int i = 0; i < NL; i++) begin
            vec_in[i*LW +: LW] = 32'h1000_0000 + i;
            exp[i*LW +: LW]    = 32'h1000_0000 + i;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL vec_in_ready: got %b exp 1", in_ready);
        end
        @(negedge clk);
        in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || vec_out !== exp || sel_err !== 1'b0) begin
            fails++;
            $display("FAIL vec_pass: got v=%b err=%b %h exp v=1 err=0 %h",
                     out_valid, sel_err, vec_out, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_broadcast();
        logic [V-1:0] exp;
        @(negedge clk);
        out_ready = 1; in_valid = 1; sel = 2'd2; lane_mask = 6'b101001;
        vec_in = rand_vec();
        scalar_in = {$urandom, 32'hDEAD_BEEF, $urandom};
        exp = '0;
        exp[0*LW +: LW] = 32'hDEAD_BEEF;
        exp[3*LW +: LW] = 32'hDEAD_BEEF;
        exp[5*LW +: LW] = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || vec_out !== exp || sel_err !== 1'b0) begin
            fails++;
            $display("FAIL bcast_mask: got v=%b err=%b %h exp v=1 err=0 %h",
                     out_valid, sel_err, vec_out, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        in_valid2 = 1; sel2 = 2'd3; lane_mask2 = 6'b111111;
        vec_in2 = rand_vec() | 192'h1;
        scalar_in2 = {$urandom | 32'h1, $urandom | 32'h1};
        @(negedge clk);
        in_valid2 = 0;
        tests++;
        if (out_valid2 !== 1'b1 || sel_err2 !== 1'b1 || vec_out2 !== '0) begin
            fails++;
            $display("FAIL illegal_sel: got v=%b err=%b %h exp v=1 err=1 0",
                     out_valid2, sel_err2, vec_out2);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [V:0] e;
        int nxt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            in_valid  = (nxt < 3);
            out_ready = (c >= 3);
            if (nxt < 3) drive_rand();
            if (c == 2) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_full_ready: got %b exp 0", in_ready);
                end
            end
            if (c >= 3 && c <= 5) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_gap c=%0d: got out_valid %b exp 1",
                             c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: got %h exp none", {sel_err, vec_out});
                end else begin
                    e = sbq.pop_front();
                    if ({sel_err, vec_out} !== e) begin
                        fails++;
                        $display("FAIL bp_order: got %h exp %h",
                                 {sel_err, vec_out}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(vec_in, scalar_in, sel, lane_mask, 3));
                nxt++;
            end
        end
        tests++;
        if (nxt != 3 || sbq.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got sent=%0d left=%0d ov=%b exp 3 0 0",
                     nxt, sbq.size(), out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [V:0] e, prev;
        logic stall = 0;
        int sent = 0, recv = 0, cyc = 0;
        prev = '0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                tests++;
                if (out_valid !== 1'b1 || {sel_err, vec_out} !== prev) begin
                    fails++;
                    $display("FAIL stream_stable: got v=%b %h exp v=1 %h",
                             out_valid, {sel_err, vec_out}, prev);
                end
            end
            in_valid  = (sent < 100) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            drive_rand();
            if (out_valid && out_ready) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: got %h exp none",
                             {sel_err, vec_out});
                end else begin
                    e = sbq.pop_front();
                    if ({sel_err, vec_out} !== e) begin
                        fails++;
                        $display("FAIL stream_data #%0d: got %h exp %h",
                                 recv, {sel_err, vec_out}, e);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(vec_in, scalar_in, sel, lane_mask, 3));
                sent++;
            end
            stall = out_valid && !out_ready;
            prev  = {sel_err, vec_out};
        end
        in_valid = 0;
        out_ready = 1;
        tests++;
        if (recv < 100) begin
            fails++;
            $display("FAIL stream_timeout: got %0d results exp 100", recv);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || sbq.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: got ov=%b left=%0d exp 0 0",
                     out_valid, sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [V:0] e;
        @(negedge clk);
        out_ready = 0; in_valid = 1; drive_rand();
        @(negedge clk);
        drive_rand();
        @(negedge clk);
        in_valid = 0;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_full: got ir=%b ov=%b exp 0 1",
                     in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            vec_out !== '0 || sel_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async: got ov=%b ir=%b err=%b %h exp 0 1 0 0",
                     out_valid, in_ready, sel_err, vec_out);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_stale: got ov=%b exp 0", out_valid);
        end
        out_ready = 1; in_valid = 1; drive_rand();
        e = model(vec_in, scalar_in, sel, lane_mask, 3);
        @(negedge clk);
        in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || {sel_err, vec_out} !== e) begin
            fails++;
            $display("FAIL rst_mid_after: got v=%b %h exp v=1 %h",
                     out_valid, {sel_err, vec_out}, e);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_dup: got ov=%b exp 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_vector_pass();
        test_broadcast();
        test_illegal();
        test_back_to_back();
        test_streaming();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_operand_select.md
Name: vec_operand_select

Overview:
- Registered, handshaked operand selector for the vector datapath.
- Chooses between a full-width vector source and NUM_SCALAR scalar sources; a selected scalar is broadcast to every lane.
- Applies a per-lane zero mask and flags out-of-range selects.
- Output passes through a 2-entry skid buffer, so it sits between register-read and the vector ALU with full valid/ready back-pressure.

Parameters:
- LANE_W, 32, bits per lane.
- LANES, 6, number of lanes; vector width V = LANES*LANE_W (192 by default).
- NUM_SCALAR, 3, number of scalar sources.
- SEL_W, $clog2(NUM_SCALAR+1), select width (2 by default).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- vec_in  input  LANES*LANE_W  vector source; lane i = bits [i*LANE_W +: LANE_W].
- scalar_in  input  NUM_SCALAR*LANE_W  scalar sources; scalar k = bits [k*LANE_W +: LANE_W].
- sel  input  SEL_W  0 = vector; 1..NUM_SCALAR = scalar sel-1 broadcast; larger = illegal.
- lane_mask  input  LANES  1 = lane enabled; 0 = lane forced to zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- vec_out  output  LANES*LANE_W  selected, masked result.
- sel_err  output  1  qualified by out_valid; result came from an illegal sel.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Both skid entries empty; out_valid=0, vec_out=0, sel_err=0, in_ready=1.
  - Reset mid-transfer discards all buffered data.
- Combinational select, per lane i:
  - sel==0: lane = vec_in lane i.
  - 1<=sel<=NUM_SCALAR: lane = scalar_in[sel-1].
  - Illegal sel: lane = 0 and err=1.
  - Then lane = lane_mask[i] ? lane : 0.
- Accept: in_valid && in_ready latches {result, err}.
  - Latency is exactly 1 cycle: accepted at edge N, out_valid high after edge N.
- Skid buffer, 2 entries, states EMPTY, ONE, FULL:
  - in_ready = (state != FULL), driven from registered state only, never from out_ready combinationally.
  - Transfer out = out_valid && out_ready. out_valid = (state != EMPTY).
  - EMPTY + accept -> ONE.
  - ONE + accept + transfer -> ONE; new data replaces head.
  - ONE + accept only -> FULL.
  - ONE + transfer only -> EMPTY.
  - ONE + neither -> ONE.
  - FULL + transfer -> ONE; skid entry moves to head.
  - FULL without transfer -> FULL.
  - Accept is impossible in FULL because in_ready=0.
- Output stability:
  - vec_out and sel_err come directly from the head register.
  - They are held stable while out_valid && !out_ready.
  - When no data is valid, vec_out holds its last value; it is not re-zeroed.
- Ordering: strict FIFO, no drop, no duplication.
- Throughput: one result per cycle sustained while out_ready=1.
- Transfer is defined on valid&&ready only; in_valid dropping without acceptance has no effect.
- Widths: no arithmetic; all zeroing is exact width, with no sign or zero extension across lanes.

Decomposition:
- Package vec_pkg:
  - LANE_W, LANES, NUM_SCALAR, V localparam.
  - Typedef lane_t = logic[LANE_W-1:0].
  - Typedef vec_t = lane_t [LANES-1:0].
  - Enum skid_state_e {EMPTY, ONE, FULL}.
  - Constant SEL_VEC = 0.
- Sub-module skid_buffer: generic 2-entry valid/ready buffer, parameterised on payload width (V+1 here). It owns the FSM and in_ready.
- The top-level holds only the lane select/mask logic, in a generate loop over lanes.

Test Plan:
- Vector pass, all lanes enabled:
  - Stimulus: sel=0, vec_in lane i = 32'h1000_0000+i, lane_mask=6'b111111, out_ready=1.
  - Response: one cycle later vec_out lane i = 32'h1000_000i, sel_err=0.
- Broadcast with mask:
  - Stimulus: sel=2, scalar_in[1]=32'hDEAD_BEEF, lane_mask=6'b101001.
  - Response: lanes 0, 3, 5 = 32'hDEAD_BEEF; lanes 1, 2, 4 = 0.
- Illegal select:
  - Stimulus: NUM_SCALAR=2 build, sel=3.
  - Response: vec_out all zero, sel_err=1 with out_valid.
- Back-pressure:
  - Stimulus: out_ready=0; offer operands A, B, C on consecutive cycles.
  - Response: A and B accepted, in_ready=0 on the 3rd cycle, C held upstream.
  - Then raise out_ready: outputs A, B, C in order, with no gaps after C is accepted.
- Streaming:
  - Stimulus: 100 random operands, random in_valid/out_ready at 50%.
  - Response: scoreboard matches exact order and content; vec_out stable while stalled.
- Reset mid-operation:
  - Stimulus: state FULL; assert rst_n=0 between clock edges.
  - Response: out_valid=0, vec_out=0 and in_ready=1 immediately, before the next edge; no stale data after release.
